addsub_pipe_n: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake, carry/borrow-in, signed/unsigned overflow detection and optional saturation.
The carry chain is cut into S registered slices, so the critical path is N/S bits and the block sustains one operation per cycle.
It sits in the datapath library as the general-purpose successor to the single-stage ripple adder, for ALU and accumulator use.

---
 rtl/addsub_pkg.sv | 33 +++
 rtl/addsub_slice.sv | 20 ++
 rtl/addsub_pipe_n.sv | 130 +++++++++++++
 tb/tb_addsub_pipe_n.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding,
// per-stage control payload and the saturation clamp selector.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control that travels with every stage. The width-dependent part of the
    // payload (pending operand chunks, partial sum, carry) is held in the top,
    // sized by its own N and S.
    typedef struct packed {
        logic vld;
        logic sub;
        logic sgn;
        logic a_msb;
    } stage_ctrl_t;

    // Clamp value encoded as {msb, fill}. The N-bit clamp is the msb followed
    // by N-1 copies of fill, which keeps this function independent of N.
    function automatic logic [1:0] sat_value(input logic sgn, input logic sub,
                                             input logic a_msb);
        logic [1:0] bits;
        if (sgn) begin
            bits = a_msb ? 2'b10 : 2'b01;
        end else if (sub == OP_SUB) begin
            bits = 2'b00;
        end else begin
            bits = 2'b11;
        end
        return bits;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational C-bit carry slice: sum, carry-out and carry into the MSB.
module addsub_slice #(
    parameter int C = 8
) (
    input  logic [C-1:0] a_i,
    input  logic [C-1:0] b_i,
    input  logic         cin_i,
    output logic [C-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);
    logic [C:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, cin_i};
    assign sum_o  = total[C-1:0];
    assign cout_o = total[C];
    // The carry entering the top bit is recovered from that bit's sum.
    assign cmsb_o = sum_o[C-1] ^ a_i[C-1] ^ b_i[C-1];

endmodule

// File: rtl/addsub_pipe_n.sv
// Pipelined N-bit adder/subtractor. The carry chain is split into S slices,
// one per register stage; upper operand chunks are skewed forward and
// finished low result chunks travel along until the last stage.
module addsub_pipe_n
    import addsub_pkg::*;
#(
    parameter int N   = 32,
    parameter int S   = 4,
    parameter int SAT = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] data0_i,
    input  logic [N-1:0] data1_i,
    input  logic         sub_i,
    input  logic         signed_i,
    input  logic         carry_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o,
    output logic         over_o,
    output logic         zero_o
);
    localparam int C = (S < 1) ? N : N / S;
    localparam logic [N-1:0] CHUNK_MASK = N'({C{1'b1}});

    if (S < 1) begin : g_bad_stages
        $error("addsub_pipe_n: S must be at least 1");
    end else if (N % S != 0) begin : g_bad_width
        $error("addsub_pipe_n: N must be a multiple of S");
    end

    // Stage registers, index k = stage k
    stage_ctrl_t  ctrl_p [S];
    logic [N-1:0] a_p    [S];
    logic [N-1:0] b_p    [S];
    logic [N-1:0] r_p    [S];
    logic         cy_p   [S];
    logic         cmsb_p;

    // Stage inputs and slice results
    stage_ctrl_t  ctrl_in [S];
    logic [N-1:0] a_in    [S];
    logic [N-1:0] b_in    [S];
    logic [N-1:0] r_in    [S];
    logic         cy_in   [S];
    logic [N-1:0] r_nx    [S];
    logic [C-1:0] sl_sum  [S];
    logic         sl_co   [S];
    logic         sl_cm   [S];

    logic         advance;
    logic         cout_last;
    logic [1:0]   sat_bits;
    logic [N-1:0] sat_word;

    assign valid_o = ctrl_p[S-1].vld;
    assign advance = ready_i || !valid_o;
    assign ready_o = advance;

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Operand prep: subtraction is A + ~B + !borrow.
            assign ctrl_in[k] = '{vld: valid_i, sub: sub_i, sgn: signed_i,
                                  a_msb: data0_i[N-1]};
            assign a_in[k]    = data0_i;
            assign b_in[k]    = (sub_i == OP_SUB) ? ~data1_i : data1_i;
            assign cy_in[k]   = (sub_i == OP_SUB) ? !carry_i : carry_i;
            assign r_in[k]    = '0;
        end else begin : g_next
            assign ctrl_in[k] = ctrl_p[k-1];
            assign a_in[k]    = a_p[k-1];
            assign b_in[k]    = b_p[k-1];
            assign cy_in[k]   = cy_p[k-1];
            assign r_in[k]    = r_p[k-1];
        end

        addsub_slice #(.C(C)) u_slice (
            .a_i    (a_in[k][k*C +: C]),
            .b_i    (b_in[k][k*C +: C]),
            .cin_i  (cy_in[k]),
            .sum_o  (sl_sum[k]),
            .cout_o (sl_co[k]),
            .cmsb_o (sl_cm[k])
        );

        // Drop this stage's finished chunk into the travelling result.
        assign r_nx[k] = (r_in[k] & ~(CHUNK_MASK << (k*C)))
                       | (N'(sl_sum[k]) << (k*C));
    end

    // Whole pipe shifts together on advance and holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < S; k++) begin
                ctrl_p[k] <= '0;
                a_p[k]    <= '0;
                b_p[k]    <= '0;
                r_p[k]    <= '0;
                cy_p[k]   <= 1'b0;
            end
            cmsb_p <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < S; k++) begin
                ctrl_p[k] <= ctrl_in[k];
                a_p[k]    <= a_in[k];
                b_p[k]    <= b_in[k];
                r_p[k]    <= r_nx[k];
                cy_p[k]   <= sl_co[k];
            end
            cmsb_p <= sl_cm[S-1];
        end
    end

    // Output flags, optional clamp and zero detect from the last stage.
    always_comb begin
        cout_last = cy_p[S-1];
        carry_o   = (ctrl_p[S-1].sub == OP_SUB) ? !cout_last : cout_last;
        over_o    = ctrl_p[S-1].sgn ? (cmsb_p ^ cout_last) : carry_o;
        sat_bits  = sat_value(ctrl_p[S-1].sgn, ctrl_p[S-1].sub, ctrl_p[S-1].a_msb);
        sat_word  = {N{sat_bits[0]}};
        sat_word[N-1] = sat_bits[1];
        sum_o     = ((SAT != 0) && over_o) ? sat_word : r_p[S-1];
        zero_o    = valid_o && (sum_o == '0);
    end

endmodule

// File: tb/tb_addsub_pipe_n.sv
// Bench for addsub_pipe_n with N=8, S=2: one wrapping and one saturating
// instance share inputs and are compared cycle by cycle with a reference.
module tb_addsub_pipe_n;

    localparam int NT = 8;
    localparam int ST = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic          ready_i;
    logic [NT-1:0] data0_i;
    logic [NT-1:0] data1_i;
    logic          sub_i;
    logic          signed_i;
    logic          carry_i;

    logic          ready_w, valid_w, carry_w, over_w, zero_w;
    logic [NT-1:0] sum_w;
    logic          ready_s, valid_s, carry_s, over_s, zero_s;
    logic [NT-1:0] sum_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    addsub_pipe_n #(.N(NT), .S(ST), .SAT(0)) u_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_w),
        .data0_i(data0_i), .data1_i(data1_i), .sub_i(sub_i), .signed_i(signed_i),
        .carry_i(carry_i), .valid_o(valid_w), .ready_i(ready_i), .sum_o(sum_w),
        .carry_o(carry_w), .over_o(over_w), .zero_o(zero_w)
    );

    addsub_pipe_n #(.N(NT), .S(ST), .SAT(1)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_s),
        .data0_i(data0_i), .data1_i(data1_i), .sub_i(sub_i), .signed_i(signed_i),
        .carry_i(carry_i), .valid_o(valid_s), .ready_i(ready_i), .sum_o(sum_s),
        .carry_o(carry_s), .over_o(over_s), .zero_o(zero_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, result as {zero, over, carry, sum}.
    function automatic logic [10:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub, input logic sgn,
                                           input logic cin, input logic sat);
        int ua, ub, sa, sb, ures, sres;
        logic carry, over;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            ures  = ua + ub + int'(cin);
            sres  = sa + sb + int'(cin);
            carry = (ures > 255);
        end else begin
            ures  = ua - ub - int'(cin);
            sres  = sa - sb - int'(cin);
            carry = (ures < 0);
        end
        res  = ures[7:0];
        over = sgn ? ((sres > 127) || (sres < -128)) : carry;
        if (sat && over) begin
            if (sgn) res = a[7] ? 8'h80 : 8'h7F;
            else     res = sub ? 8'h00 : 8'hFF;
        end
        return {(res == 8'h00), over, carry, res};
    endfunction

    // Directed operations: {a, b, sub, sgn, cin}
    localparam int ND = 10;
    logic [18:0] dir_ops [ND] = '{
        {8'h7F, 8'h01, 1'b0, 1'b0, 1'b0},
        {8'h7F, 8'h01, 1'b0, 1'b1, 1'b0},
        {8'hFF, 8'h01, 1'b0, 1'b0, 1'b0},
        {8'h00, 8'h00, 1'b0, 1'b0, 1'b1},
        {8'h05, 8'h07, 1'b1, 1'b0, 1'b0},
        {8'h05, 8'h07, 1'b1, 1'b1, 1'b0},
        {8'h70, 8'h20, 1'b0, 1'b1, 1'b0},
        {8'h80, 8'hFF, 1'b0, 1'b1, 1'b0},
        {8'h10, 8'h20, 1'b0, 1'b1, 1'b0},
        {8'h80, 8'h01, 1'b1, 1'b1, 1'b1}
    };
    int di = 0;

    logic [7:0] op_a, op_b;
    logic       op_sub, op_sgn, op_cin;

    // Pipeline occupancy model: slot k holds what stage k should contain.
    logic        m_vld [ST];
    logic [10:0] m_w   [ST];
    logic [10:0] m_s   [ST];

    task automatic next_op();
        logic [18:0] d;
        if (di < ND) begin
            d = dir_ops[di];
            di++;
            {op_a, op_b, op_sub, op_sgn, op_cin} = d;
        end else begin
            op_a   = 8'($urandom);
            op_b   = 8'($urandom);
            op_sub = 1'($urandom);
            op_sgn = 1'($urandom);
            op_cin = 1'($urandom);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < ST; k++) begin
            m_vld[k] = 1'b0;
            m_w[k]   = '0;
            m_s[k]   = '0;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input logic vin, input logic rin);
        logic adv;
        valid_i  = vin;
        ready_i  = rin;
        data0_i  = op_a;
        data1_i  = op_b;
        sub_i    = op_sub;
        signed_i = op_sgn;
        carry_i  = op_cin;
        #1;
        adv = rin || !m_vld[ST-1];
        check_val("ready_o_wrap", ready_w, adv);
        check_val("ready_o_sat", ready_s, adv);
        check_val("valid_o_wrap", valid_w, m_vld[ST-1]);
        check_val("valid_o_sat", valid_s, m_vld[ST-1]);
        if (m_vld[ST-1]) begin
            check_val("sum_wrap", sum_w, m_w[ST-1][7:0]);
            check_val("carry_wrap", carry_w, m_w[ST-1][8]);
            check_val("over_wrap", over_w, m_w[ST-1][9]);
            check_val("zero_wrap", zero_w, m_w[ST-1][10]);
            check_val("sum_sat", sum_s, m_s[ST-1][7:0]);
            check_val("carry_sat", carry_s, m_s[ST-1][8]);
            check_val("over_sat", over_s, m_s[ST-1][9]);
            check_val("zero_sat", zero_s, m_s[ST-1][10]);
        end
        if (adv) begin
            for (int k = ST - 1; k > 0; k--) begin
                m_vld[k] = m_vld[k-1];
                m_w[k]   = m_w[k-1];
                m_s[k]   = m_s[k-1];
            end
            m_vld[0] = vin;
            m_w[0]   = ref_op(op_a, op_b, op_sub, op_sgn, op_cin, 1'b0);
            m_s[0]   = ref_op(op_a, op_b, op_sub, op_sgn, op_cin, 1'b1);
        end
        @(posedge clk_i);
        if (vin && adv) next_op();
        @(negedge clk_i);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid_wrap"}, valid_w, 1'b0);
        check_val({tag, "_valid_sat"}, valid_s, 1'b0);
        check_val({tag, "_sum_wrap"}, sum_w, 8'h00);
        check_val({tag, "_sum_sat"}, sum_s, 8'h00);
        check_val({tag, "_carry_wrap"}, carry_w, 1'b0);
        check_val({tag, "_over_wrap"}, over_w, 1'b0);
        check_val({tag, "_zero_wrap"}, zero_w, 1'b0);
        check_val({tag, "_zero_sat"}, zero_s, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        data0_i  = '0;
        data1_i  = '0;
        sub_i    = 1'b0;
        signed_i = 1'b0;
        carry_i  = 1'b0;
        model_clear();
        next_op();

        repeat (2) @(negedge clk_i);
        #1;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_val("ready_after_reset_wrap", ready_w, 1'b1);
        check_val("ready_after_reset_sat", ready_s, 1'b1);
        @(negedge clk_i);

        // Directed cases, back to back.
        repeat (ND) step(1'b1, 1'b1);

        // Six back-to-back ops with the sink stalled three cycles mid-stream.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        // Random traffic with random source and sink gaps.
        repeat (400) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
        repeat (4) step(1'b0, 1'b1);

        // Reset with two operations in flight.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_idle_outputs("post_reset");
        @(negedge clk_i);
        step(1'b1, 1'b1);
        repeat (ST + 2) step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
